cache_flush_seq: RTL and testbench
==================================

# cache_flush_seq

Flush sequencer for the set-associative L1 caches. On a flush command it walks every set of the tag/dirty arrays, issues one write-back request per valid dirty way over a req/ack handshake, and then clears that way's dirty bit. It sits beside the replacement logic and drives the cache's flush-address mux and dirty-clear enables. It pulses `FlushDone` when the whole array is clean.

## Interface
- `NUMWAYS`, 4: associativity; power of 2, at least 1.
- `SETLEN`, 7: set-index width.
- `NUMLINES`, 128: number of sets; must equal 2^SETLEN.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (asserted at 0).
- `FlushCache` in 1: flush command; sampled only in IDLE.
- `ValidWay` in NUMWAYS: valid bits of the set at `FlushAdr`; meaningful in CHECK.
- `DirtyWay` in NUMWAYS: dirty bits of the set at `FlushAdr`; meaningful in CHECK.
- `WBAck` in 1: write-back accepted; meaningful only while `WBReq`=1.
- `FlushAdr` out SETLEN: set index presented to the arrays.
- `FlushWay` out NUMWAYS: one-hot way under write-back or clear; 0 otherwise.
- `WBReq` out 1: write-back request for `FlushAdr`/`FlushWay`.
- `ClearDirty` out 1: one-cycle dirty-clear enable for `FlushAdr`/`FlushWay`.
- `Busy` out 1: sequencer active (any state except IDLE).
- `FlushDone` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, READ, CHECK, WB, CLEAR, DONE.
- Internal state: a SETLEN-bit set counter `Set` (drives `FlushAdr`) and a NUMWAYS-bit `Pending` mask register.
- IDLE:
  - `FlushCache`=1 gives `Set`<=0, then READ.
  - Otherwise stay in IDLE.
- READ: `FlushAdr`=`Set`; the arrays read synchronously. Always go to CHECK.
- CHECK: `Pending`<=`ValidWay` & `DirtyWay`.
  - Nonzero mask: go to WB.
  - Zero mask and `Set`=NUMLINES-1: go to DONE.
  - Zero mask otherwise: `Set`<=`Set`+1, then READ.
- WB: `WBReq`=1; `FlushWay` = lowest-index set bit of `Pending`.
  - Hold `WBReq`, `FlushWay` and `FlushAdr` stable until a `WBAck`=1 edge.
  - The ack edge goes to CLEAR.
- CLEAR: `ClearDirty`=1, `WBReq`=0, `FlushWay` unchanged. Remove that way from `Pending`.
  - Remaining bits: go to WB.
  - None remaining and `Set`=NUMLINES-1: go to DONE.
  - None remaining otherwise: `Set`+1, then READ.
- DONE: `FlushDone`=1 and `Busy`=1 for one cycle, then IDLE.
- Ways are serviced in ascending index order.
- The `Pending` mask is a snapshot taken in CHECK. Changes to `DirtyWay` after CHECK are ignored for that set.
- `Set` increments modulo 2^SETLEN; it never wraps during a flush because the last set exits to DONE. It resets to 0.
- Ignored inputs:
  - `FlushCache` outside IDLE has no effect; there is no queueing.
  - `WBAck` outside WB has no effect.
- `FlushCache` held high through DONE starts a new flush from IDLE on the following edge.

## Timing
- Reset (`reset`=0): state IDLE, `Set`=0, `Pending`=0. All outputs 0, including `FlushAdr`=0 and `FlushWay`=0.
- Reset mid-operation:
  - Immediate abort and no `ClearDirty` pulse.
  - An outstanding `WBReq` drops asynchronously.
  - The handshake partner must treat this as a cancel.
- Outputs are decoded from registered state only; there are no input-to-output combinational paths.
- Let E0 be the edge that samples `FlushCache`=1 in IDLE:
  - READ for set 0 begins after E0.
  - A clean set costs 2 cycles.
  - A fully clean cache raises `FlushDone` in the cycle after edge E0+2·NUMLINES; `Busy` falls one edge later.
- Each dirty way adds (W+1) cycles, where W = WB cycles including the ack cycle; the minimum is 2 cycles with `WBAck` held at 1.
- `WBAck` may already be high when WB is entered; that is accepted on the first WB edge.

## Test plan
- All-clean cache, NUMLINES=128: pulse `FlushCache`.
  - Expect `FlushAdr` to step 0..127, each set for 2 cycles.
  - Expect `WBReq` never asserted.
  - Expect `FlushDone` exactly 256 cycles after E0, and `Busy` low 1 cycle later.
- Set 5 returns Valid=1111 and Dirty=1010, `WBAck` high 1 cycle after each `WBReq`:
  - Expect `FlushWay`=0010 then 1000, each held until its ack.
  - Expect one `ClearDirty` per way, at `FlushAdr`=5.
  - Expect 6 extra cycles in total.
- Dirty but invalid way (Valid=1110, Dirty=0001) at set 0 -> no `WBReq`; set 0 takes 2 cycles.
- Stalled ack: `WBAck` held 0 for 20 cycles at set 127 way 0.
  - Expect `WBReq`, `FlushAdr`=127 and `FlushWay`=0001 stable throughout.
  - After the ack: CLEAR, then DONE, with no increment to set 0.
- `FlushCache` pulsed while `Busy` is high and `WBAck` pulsed in READ -> both ignored; the set sequence and `FlushDone` timing are unchanged.
- `reset` driven to 0 during WB at set 40, then released -> outputs 0 immediately, no `ClearDirty`; the next `FlushCache` restarts from set 0.

Source files
------------

// File: rtl/cache_flush_seq.sv
// Flush sequencer: walks every set, writes back valid dirty ways in
// ascending order over a req/ack handshake, then clears each dirty bit.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   FlushCache      flush command, sampled in IDLE
//   ValidWay        valid bits of the set at FlushAdr (read in CHECK)
//   DirtyWay        dirty bits of the set at FlushAdr (read in CHECK)
//   WBAck           write-back accepted (used only while WBReq=1)
//   FlushAdr        set index presented to the tag/dirty arrays
//   FlushWay        one-hot way under write-back or clear, else 0
//   WBReq           write-back request for FlushAdr/FlushWay
//   ClearDirty      one-cycle dirty-clear enable for FlushAdr/FlushWay
//   Busy            sequencer active
//   FlushDone       one-cycle completion pulse
module cache_flush_seq #(
    parameter int NUMWAYS  = 4,
    parameter int SETLEN   = 7,
    parameter int NUMLINES = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushCache,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WBAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WBReq,
    output logic               ClearDirty,
    output logic               Busy,
    output logic               FlushDone
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] WB    = 3'd3;
    localparam logic [2:0] CLEAR = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMLINES - 1);
    localparam logic [SETLEN-1:0] ONESET  = SETLEN'(1);

    logic [2:0]         state;
    logic [2:0]         nextState;
    logic [SETLEN-1:0]  Set;
    logic [NUMWAYS-1:0] Pending;
    logic [NUMWAYS-1:0] lowWay;
    logic [NUMWAYS-1:0] candMask;
    logic [NUMWAYS-1:0] remMask;
    logic               lowFound;
    logic               lastSet;

    assign candMask = ValidWay & DirtyWay;
    assign lastSet  = (Set == LASTSET);
    assign remMask  = Pending & ~lowWay;

    // Lowest-index pending way; gives ascending service order.
    always_comb begin
        lowWay   = '0;
        lowFound = 1'b0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (Pending[i] && !lowFound) begin
                lowWay[i] = 1'b1;
                lowFound  = 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (FlushCache) nextState = READ;
            READ:  nextState = CHECK;
            CHECK: begin
                if (candMask != '0) nextState = WB;
                else if (lastSet)   nextState = DONE;
                else                nextState = READ;
            end
            WB:    if (WBAck) nextState = CLEAR;
            CLEAR: begin
                if (remMask != '0) nextState = WB;
                else if (lastSet)  nextState = DONE;
                else               nextState = READ;
            end
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            Set     <= '0;
            Pending <= '0;
        end else begin
            state <= nextState;
            unique case (state)
                IDLE: if (FlushCache) Set <= '0;
                CHECK: begin
                    // Snapshot: later DirtyWay changes do not affect this set.
                    Pending <= candMask;
                    if (candMask == '0 && !lastSet) Set <= Set + ONESET;
                end
                CLEAR: begin
                    Pending <= remMask;
                    if (remMask == '0 && !lastSet) Set <= Set + ONESET;
                end
                default: ;
            endcase
        end
    end

    // Pending still holds the cleared way during CLEAR, so lowWay is stable.
    assign FlushAdr   = Set;
    assign WBReq      = (state == WB);
    assign ClearDirty = (state == CLEAR);
    assign FlushWay   = (state == WB || state == CLEAR) ? lowWay : '0;
    assign Busy       = (state != IDLE);
    assign FlushDone  = (state == DONE);

endmodule

// File: tb/tb_cache_flush_seq.sv
// Self-checking bench for cache_flush_seq: a per-cycle expected trace is
// built from the cache contents and a chosen ack latency per write-back.
module tb_cache_flush_seq;

    localparam int NW = 4;
    localparam int SL = 7;
    localparam int NL = 128;

    logic          clk;
    logic          reset;
    logic          FlushCache;
    logic [NW-1:0] ValidWay;
    logic [NW-1:0] DirtyWay;
    logic          WBAck;
    logic [SL-1:0] FlushAdr;
    logic [NW-1:0] FlushWay;
    logic          WBReq;
    logic          ClearDirty;
    logic          Busy;
    logic          FlushDone;

    cache_flush_seq #(.NUMWAYS(NW), .SETLEN(SL), .NUMLINES(NL)) dut (
        .clk(clk),
        .reset(reset),
        .FlushCache(FlushCache),
        .ValidWay(ValidWay),
        .DirtyWay(DirtyWay),
        .WBAck(WBAck),
        .FlushAdr(FlushAdr),
        .FlushWay(FlushWay),
        .WBReq(WBReq),
        .ClearDirty(ClearDirty),
        .Busy(Busy),
        .FlushDone(FlushDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NW-1:0] validArr [NL];
    logic [NW-1:0] dirtyArr [NL];

    // Array read: FlushAdr is registered and stable while READ/CHECK.
    assign ValidWay = validArr[FlushAdr];
    assign DirtyWay = dirtyArr[FlushAdr];

    typedef struct packed {
        logic [SL-1:0] adr;
        logic          req;
        logic [NW-1:0] way;
        logic          clr;
        logic          done;
        logic          ack;
    } cyc_t;

    cyc_t trace[$];

    int checks = 0;
    int errors = 0;
    int doneAt;

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({FlushAdr, WBReq, FlushWay, ClearDirty, Busy, FlushDone});
    endfunction

    // Expected cycle sequence: each set reads and checks (2 cycles),
    // every valid dirty way costs W request cycles plus one clear,
    // and one DONE cycle closes the flush.
    task automatic buildTrace(input int forceSet, input int forceW);
        cyc_t e;
        logic [NW-1:0] m;
        logic [NW-1:0] oh;
        int wbLen;
        trace.delete();
        for (int s = 0; s < NL; s++) begin
            e = '0;
            e.adr = SL'(s);
            trace.push_back(e);
            trace.push_back(e);
            m = validArr[s] & dirtyArr[s];
            for (int w = 0; w < NW; w++) begin
                if (m[w]) begin
                    oh = '0;
                    oh[w] = 1'b1;
                    wbLen = (s == forceSet) ? forceW : 1 + $urandom_range(0, 3);
                    for (int k = 0; k < wbLen; k++) begin
                        e = '0;
                        e.adr = SL'(s);
                        e.req = 1'b1;
                        e.way = oh;
                        e.ack = (k == wbLen - 1);
                        trace.push_back(e);
                    end
                    e = '0;
                    e.adr = SL'(s);
                    e.way = oh;
                    e.clr = 1'b1;
                    trace.push_back(e);
                end
            end
        end
        e = '0;
        e.adr = SL'(NL - 1);
        e.done = 1'b1;
        trace.push_back(e);
    endtask

    task automatic runFlush(input bit noise, input int abortIdx,
                            output int doneIdx);
        cyc_t t;
        int last;
        doneIdx = -1;
        last = trace.size() - 1;
        @(negedge clk);
        FlushCache = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= last; i++) begin
            t = trace[i];
            checkEq("cycle", outVec(),
                    32'({t.adr, t.req, t.way, t.clr, 1'b1, t.done}));
            if (FlushDone && doneIdx < 0) doneIdx = i;
            if (i == abortIdx) begin
                reset = 1'b0;
                #1;
                checkEq("abortOut", outVec(), 32'd0);
                WBAck = 1'b0;
                FlushCache = 1'b0;
                @(negedge clk);
                checkEq("abortHold", outVec(), 32'd0);
                reset = 1'b1;
                @(negedge clk);
                checkEq("abortIdle",
                        32'({Busy, WBReq, ClearDirty, FlushDone}), 32'd0);
                return;
            end
            if (t.clr) dirtyArr[t.adr] = dirtyArr[t.adr] & ~t.way;
            FlushCache = (noise && i < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (t.req) WBAck = t.ack;
            else       WBAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        FlushCache = 1'b0;
        WBAck = 1'b0;
        checkEq("idleAfter",
                32'({Busy, FlushDone, WBReq, ClearDirty, FlushWay}), 32'd0);
    endtask

    task automatic fillClean();
        for (int s = 0; s < NL; s++) begin
            validArr[s] = NW'($urandom);
            dirtyArr[s] = '0;
        end
    endtask

    task automatic fillRandom();
        for (int s = 0; s < NL; s++) begin
            validArr[s] = NW'($urandom);
            dirtyArr[s] = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
        end
    endtask

    initial begin
        int abortIdx;
        reset = 1'b0;
        FlushCache = 1'b0;
        WBAck = 1'b0;
        for (int s = 0; s < NL; s++) begin
            validArr[s] = '0;
            dirtyArr[s] = '0;
        end
        #12;
        checkEq("resetOut", outVec(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkEq("idleOut", outVec(), 32'd0);

        // All clean: done 256 cycles after E0.
        fillClean();
        buildTrace(-1, 0);
        runFlush(1'b0, -1, doneAt);
        checkEq("cleanDone", 32'(doneAt), 32'd256);

        // Set 5: ways 1 and 3, ack one cycle after request.
        fillClean();
        validArr[5] = 4'b1111;
        dirtyArr[5] = 4'b1010;
        buildTrace(5, 2);
        runFlush(1'b0, -1, doneAt);
        checkEq("set5Done", 32'(doneAt), 32'd262);
        checkEq("set5Clean", 32'(dirtyArr[5]), 32'd0);

        // Dirty but invalid way is skipped.
        fillClean();
        validArr[0] = 4'b1110;
        dirtyArr[0] = 4'b0001;
        buildTrace(-1, 0);
        runFlush(1'b0, -1, doneAt);
        checkEq("invalidDone", 32'(doneAt), 32'd256);

        // Stalled ack on the last set: 20 low cycles, then ack.
        fillClean();
        validArr[NL-1] = 4'b0001;
        dirtyArr[NL-1] = 4'b0001;
        buildTrace(NL - 1, 21);
        runFlush(1'b0, -1, doneAt);
        checkEq("stallDone", 32'(doneAt), 32'd278);

        // Ignored FlushCache/WBAck noise does not move the schedule.
        fillRandom();
        buildTrace(-1, 0);
        runFlush(1'b1, -1, doneAt);
        checkEq("noiseDone", 32'(doneAt), 32'(trace.size() - 1));

        // Reset during a write-back at set 40, then restart from set 0.
        fillRandom();
        validArr[40] = 4'b0100;
        dirtyArr[40] = 4'b0100;
        buildTrace(40, 4);
        abortIdx = -1;
        for (int i = 0; i < trace.size(); i++) begin
            if (abortIdx < 0 && trace[i].adr == SL'(40) && trace[i].req)
                abortIdx = i;
        end
        runFlush(1'b0, abortIdx, doneAt);
        checkEq("abortDirty", 32'(dirtyArr[40]), 32'h4);
        buildTrace(-1, 0);
        runFlush(1'b0, -1, doneAt);
        checkEq("restartDone", 32'(doneAt), 32'(trace.size() - 1));

        for (int r = 0; r < 3; r++) begin
            fillRandom();
            buildTrace(-1, 0);
            runFlush(1'b1, -1, doneAt);
            checkEq("randDone", 32'(doneAt), 32'(trace.size() - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
